// File: rtl/pico_bus_fabric_if.sv
// Bus bundle between the PicoRV32 native memory port and the fabric's slave ports.
// master: the CPU/peripheral side surrounding the fabric; slave: the fabric itself.
interface pico_bus_fabric_if #(
    parameter int unsigned N_SLAVES = 4
);
    logic                   mem_valid;
    logic [31:0]            mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_wstrb;
    logic                   mem_ready;
    logic [31:0]            mem_rdata;

    logic [N_SLAVES-1:0]    s_valid;
    logic [31:0]            s_addr;
    logic [31:0]            s_wdata;
    logic [3:0]             s_wstrb;
    logic [N_SLAVES-1:0]    s_ready;
    logic [N_SLAVES*32-1:0] s_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata
    );
endinterface

// File: rtl/pico_bus_fabric.sv
// Address-decoding bus fabric: one PicoRV32 master to N_SLAVES slaves with error termination.
// Optional watchdog on slave ready is enabled by defining BUS_TIMEOUT_EN.
module pico_bus_fabric #(
    parameter int unsigned            N_SLAVES       = 4,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000,
                                                        32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK     = {4{32'hFF00_0000}},
    parameter int unsigned            TIMEOUT_CYCLES = 1024,
    parameter logic [31:0]            ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               resetn,
    pico_bus_fabric_if.slave   bus,
    input  logic               i_err_clr,
    output logic               o_bus_err,
    output logic               o_err_sticky,
    output logic [1:0]         o_err_cause,
    output logic [31:0]        o_err_addr
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR,
        DONE
    } state_e;

    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;

    if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_n_slaves
        $error("pico_bus_fabric: N_SLAVES must be in 1..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("pico_bus_fabric: TIMEOUT_CYCLES must be at least 2");
    end

    state_e              state_q;
    logic [N_SLAVES-1:0] sel_q;
    logic [N_SLAVES-1:0] s_valid_q;
    logic [N_SLAVES-1:0] hit_d;
    logic [31:0]         addr_q;
    logic                write_q;
    logic                mem_ready_q;
    logic [31:0]         mem_rdata_q;
    logic                bus_err_q;
    logic                err_sticky_q;
    logic [1:0]          err_cause_q;
    logic [31:0]         err_addr_q;
    logic                ready_sel;
    logic [31:0]         rdata_sel;

    // Lowest-indexed matching slot wins when decode windows overlap.
    always_comb begin
        hit_d = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (hit_d == '0 &&
                (bus.mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ready_sel = |(bus.s_ready & sel_q);
        rdata_sel = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (sel_q[i]) begin
                rdata_sel = bus.s_rdata[32*i +: 32];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0]  CAUSE_TIMEOUT = 2'b10;

    logic [CNT_W-1:0] cnt_q;
    logic             timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn || state_q != WAIT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            s_valid_q    <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            mem_ready_q  <= 1'b0;
            mem_rdata_q  <= '0;
            bus_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cause_q  <= '0;
            err_addr_q   <= '0;
        end else begin
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            // A clear is overridden below when an error completes on the same edge.
            if (i_err_clr) begin
                err_sticky_q <= 1'b0;
                err_cause_q  <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (bus.mem_valid) begin
                        addr_q  <= bus.mem_addr;
                        write_q <= |bus.mem_wstrb;
                        if (|hit_d) begin
                            sel_q     <= hit_d;
                            s_valid_q <= hit_d;
                            state_q   <= WAIT;
                        end else begin
                            state_q <= ERR;
                        end
                    end
                end
                WAIT: begin
                    if (ready_sel) begin
                        mem_rdata_q <= write_q ? '0 : rdata_sel;
                        mem_ready_q <= 1'b1;
                        s_valid_q   <= '0;
                        state_q     <= DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (timeout) begin
                        mem_rdata_q  <= ERR_RDATA;
                        mem_ready_q  <= 1'b1;
                        bus_err_q    <= 1'b1;
                        err_sticky_q <= 1'b1;
                        err_cause_q  <= CAUSE_TIMEOUT;
                        err_addr_q   <= addr_q;
                        s_valid_q    <= '0;
                        state_q      <= DONE;
                    end
`endif
                end
                ERR: begin
                    mem_rdata_q  <= ERR_RDATA;
                    mem_ready_q  <= 1'b1;
                    bus_err_q    <= 1'b1;
                    err_sticky_q <= 1'b1;
                    err_cause_q  <= CAUSE_UNMAPPED;
                    err_addr_q   <= addr_q;
                    state_q      <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.s_valid   = s_valid_q;
    assign bus.s_addr    = bus.mem_addr;
    assign bus.s_wdata   = bus.mem_wdata;
    assign bus.s_wstrb   = bus.mem_wstrb;

    assign o_bus_err    = bus_err_q;
    assign o_err_sticky = err_sticky_q;
    assign o_err_cause  = err_cause_q;
    assign o_err_addr   = err_addr_q;

endmodule

// File: tb/tb_pico_bus_fabric.sv
// Directed bench for pico_bus_fabric: vector table plus hand sequences for errors, timeout and reset.
// Slot 1 is widened (mask E000_0000) so it overlaps slot 0 around address 0.
module tb_pico_bus_fabric;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdy_slot;
        int          rdy_k;
        logic [3:0]  decoy;
        int          exp_cycle;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_sel;
        int          exp_sv;
        logic        exp_err;
        logic [1:0]  exp_cause;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        err_clr;
    logic        bus_err;
    logic        err_sticky;
    logic [1:0]  err_cause;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;

    pico_bus_fabric_if #(.N_SLAVES(N)) bus ();

    pico_bus_fabric #(
        .N_SLAVES       (N),
        .SLAVE_BASE     ({32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hFF00_0000, 32'hFF00_0000, 32'hE000_0000, 32'hFF00_0000}),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus.slave),
        .i_err_clr    (err_clr),
        .o_bus_err    (bus_err),
        .o_err_sticky (err_sticky),
        .o_err_cause  (err_cause),
        .o_err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Cycle 0 is the first cycle mem_valid is high; inputs change and outputs are sampled on negedges.
    task automatic do_txn(input vec_t v, input int maxc, input string nm);
        int          c = 0;
        bit          done = 1'b0;
        int          sv_n = 0;
        logic [N-1:0] sv_or = '0;
        logic [N-1:0] one = 1;
        logic [31:0] rd = '0;
        logic        be = 1'b0;
        logic        st = 1'b0;
        logic [1:0]  cs = '0;
        logic [31:0] ea = '0;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = v.addr;
        bus.mem_wdata = v.wdata;
        bus.mem_wstrb = v.wstrb;
        while (!done && c <= maxc) begin
            if (c > 0) @(negedge clk);
            if (c == v.rdy_k)  bus.s_ready = one << v.rdy_slot;
            else if (c == 1)   bus.s_ready = v.decoy;
            else               bus.s_ready = '0;
            if (c == 0) begin
                #1;
                chk({nm, " s_addr"},  bus.s_addr,  v.addr);
                chk({nm, " s_wdata"}, bus.s_wdata, v.wdata);
                chk({nm, " s_wstrb"}, {28'b0, bus.s_wstrb}, {28'b0, v.wstrb});
            end
            if (bus.s_valid != '0) begin
                sv_or |= bus.s_valid;
                sv_n++;
            end
            if (bus.mem_ready) begin
                done = 1'b1;
                rd = bus.mem_rdata;
                be = bus_err;
                st = err_sticky;
                cs = err_cause;
                ea = err_addr;
            end else begin
                c++;
            end
        end
        if (v.exp_cycle < 0) begin
            chk({nm, " no_ready"}, {31'b0, done}, 32'd0);
        end else if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s ready_cycle: got none within %0d expected %0d", nm, maxc, v.exp_cycle);
            bus.mem_valid = 1'b0;
            bus.s_ready   = '0;
        end else begin
            chk({nm, " ready_cycle"}, c, v.exp_cycle);
            chk({nm, " rdata"},       rd, v.exp_rdata);
            chk({nm, " s_valid_sel"}, {28'b0, sv_or}, {28'b0, v.exp_sel});
            chk({nm, " s_valid_len"}, sv_n, v.exp_sv);
            chk({nm, " bus_err"},     {31'b0, be}, {31'b0, v.exp_err});
            chk({nm, " sticky"},      {31'b0, st}, {31'b0, v.exp_err});
            chk({nm, " cause"},       {30'b0, cs}, {30'b0, v.exp_cause});
            if (v.exp_err) chk({nm, " err_addr"}, ea, v.addr);
            bus.mem_valid = 1'b0;
            bus.s_ready   = '0;
            @(negedge clk);
            chk({nm, " ready_pulse"}, {31'b0, bus.mem_ready}, 32'd0);
            chk({nm, " err_pulse"},   {31'b0, bus_err}, 32'd0);
        end
    endtask

    vec_t vecs[8];
    vec_t hv;

    initial begin
        // addr, wdata, wstrb, rdy_slot, rdy_k, decoy, exp_cycle, exp_rdata, exp_sel, exp_sv, exp_err, exp_cause
        vecs[0] = '{32'h0000_0010, 32'h0, 4'h0, 0, 2, 4'b0000, 3, 32'h1234_5678, 4'b0001, 2, 1'b0, 2'b00};
        vecs[1] = '{32'h2000_0000, 32'h41, 4'h1, 2, 1, 4'b0000, 2, 32'h0000_0000, 4'b0100, 1, 1'b0, 2'b00};
        vecs[2] = '{32'h5000_0000, 32'h0, 4'h0, 0, 1, 4'b0000, 2, 32'hDEAD_BEEF, 4'b0000, 0, 1'b1, 2'b01};
        vecs[3] = '{32'h3000_0004, 32'h0, 4'h0, 3, 4, 4'b0111, 5, 32'h4444_4444, 4'b1000, 4, 1'b0, 2'b00};
        vecs[4] = '{32'h1000_0020, 32'h0, 4'h0, 1, 1, 4'b0000, 2, 32'h2222_2222, 4'b0010, 1, 1'b0, 2'b00};
        vecs[5] = '{32'h0000_0000, 32'hCAFE_F00D, 4'hF, 0, 3, 4'b0010, 4, 32'h0000_0000, 4'b0001, 3, 1'b0, 2'b00};
        vecs[6] = '{32'hF000_0000, 32'h55, 4'h3, 0, 1, 4'b0000, 2, 32'hDEAD_BEEF, 4'b0000, 0, 1'b1, 2'b01};
        vecs[7] = '{32'h2000_00FC, 32'h0, 4'h0, 2, 1, 4'b0000, 2, 32'h3333_3333, 4'b0100, 1, 1'b0, 2'b00};

        resetn        = 1'b0;
        err_clr       = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.s_ready   = '0;
        bus.s_rdata   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1234_5678};

        repeat (3) @(negedge clk);
        chk("rst mem_ready",  {31'b0, bus.mem_ready}, 32'd0);
        chk("rst mem_rdata",  bus.mem_rdata, 32'd0);
        chk("rst s_valid",    {28'b0, bus.s_valid}, 32'd0);
        chk("rst bus_err",    {31'b0, bus_err}, 32'd0);
        chk("rst sticky",     {31'b0, err_sticky}, 32'd0);
        chk("rst cause",      {30'b0, err_cause}, 32'd0);
        chk("rst err_addr",   err_addr, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i], 50, $sformatf("v%0d", i));
            @(negedge clk);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
        end

        // Sticky error persists until cleared; address survives the clear.
        do_txn(vecs[2], 50, "err_seq");
        repeat (3) @(negedge clk);
        chk("err_hold sticky", {31'b0, err_sticky}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr sticky",   {31'b0, err_sticky}, 32'd0);
        chk("err_clr cause",    {30'b0, err_cause}, 32'd0);
        chk("err_clr err_addr", err_addr, 32'h5000_0000);

        // Clear held across an error completion: the error wins.
        err_clr = 1'b1;
        do_txn(vecs[6], 50, "clr_vs_err");
        @(negedge clk);
        chk("clr_after sticky", {31'b0, err_sticky}, 32'd0);
        err_clr = 1'b0;

`ifdef BUS_TIMEOUT_EN
        hv = '{32'h1000_0000, 32'h0, 4'h0, 1, 1000, 4'b0000, TO + 1, 32'hDEAD_BEEF, 4'b0010, TO, 1'b1, 2'b10};
        do_txn(hv, 50, "timeout");
        hv = '{32'h1000_0000, 32'h0, 4'h0, 1, 1000, 4'b0000, -1, 32'h0, 4'b0010, 0, 1'b0, 2'b00};
        do_txn(hv, 4, "stall");
`else
        hv = '{32'h1000_0000, 32'h0, 4'h0, 1, 1000, 4'b0000, -1, 32'h0, 4'b0010, 0, 1'b0, 2'b00};
        do_txn(hv, 100, "stall");
`endif
        chk("stall s_valid", {28'b0, bus.s_valid}, 32'b0010);

        // Reset while waiting on a slave: request dropped, no response afterwards.
        @(negedge clk);
        resetn        = 1'b0;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        chk("midrst s_valid",   {28'b0, bus.s_valid}, 32'd0);
        chk("midrst mem_ready", {31'b0, bus.mem_ready}, 32'd0);
        resetn = 1'b1;
        begin
            int seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (bus.mem_ready || bus.s_valid != '0) seen++;
            end
            chk("postrst quiet", seen, 0);
        end
        do_txn(vecs[4], 50, "postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pico_bus_fabric.md
# pico_bus_fabric

Parametrised bus fabric between the PicoRV32 native memory port and N memory-mapped slaves (boot BRAM, external SRAM, UART, SD SPI bridge, and future peripherals). It replaces hard-wired top-level address decoding and ready/rdata muxing. Each transaction is decoded once, latched, and issued to exactly one slave. The master gets a registered single-cycle response. Unmapped addresses and stalled slaves are terminated with an error response, so the CPU never hangs.

## Interface
- N_SLAVES, 4, number of slave ports (1–16)
- SLAVE_BASE, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, packed N_SLAVES×32 base addresses; slot i at bits [32i+31:32i]
- SLAVE_MASK, {4{32'hFF00_0000}}, packed N_SLAVES×32 decode masks; slot i hits when (mem_addr & mask_i) == base_i
- TIMEOUT_CYCLES, 1024, maximum wait for slave ready (≥2)
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on error completion
- clk  in  1  system clock
- resetn  in  1  **synchronous, active-low reset, sampled on rising edge of clk**
- mem_valid  in  1  master request
- mem_addr  in  32  master address, stable while mem_valid
- mem_wdata  in  32  master write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_ready  out  1  registered completion pulse
- mem_rdata  out  32  registered read data, valid with mem_ready
- s_valid  out  N_SLAVES  one-hot per-slave request
- s_addr / s_wdata / s_wstrb  out  32/32/4  broadcast copies of master fields
- s_ready  in  N_SLAVES  per-slave completion
- s_rdata  in  N_SLAVES×32  packed per-slave read data
- i_err_clr  in  1  clears sticky error state
- o_bus_err  out  1  one-cycle pulse on error completion
- o_err_sticky  out  1  set on any error, held until i_err_clr
- o_err_cause  out  2  01 unmapped, 10 timeout, 00 none
- o_err_addr  out  32  address of most recent error

## Operation
- States: IDLE, WAIT, ERR, DONE.
- IDLE:
  - mem_valid=1 and a slot hits → latch one-hot sel (lowest index wins on overlap), go to WAIT.
  - No hit → ERR.
- WAIT:
  - s_valid = sel; counter increments every cycle.
  - s_ready[sel] → capture s_rdata[sel], go to DONE.
  - s_ready of unselected slots is ignored.
  - Counter reaches TIMEOUT_CYCLES−1 without ready → capture ERR_RDATA, cause=10, go to DONE. Slave ready and timeout in the same cycle: ready wins.
- ERR: capture ERR_RDATA, cause=01, go to DONE.
- DONE:
  - mem_ready=1, s_valid=0.
  - o_bus_err pulses if the transaction errored; o_err_addr, o_err_cause and o_err_sticky update on the same edge.
  - Next state is unconditionally IDLE, so the stale request is never re-decoded.
- Writes follow the same path. Write completions return mem_rdata=0, or ERR_RDATA on error.
- i_err_clr clears o_err_sticky and o_err_cause. If i_err_clr and a new error occur in the same cycle, the error wins.
- Reset values: state=IDLE; mem_ready=0, mem_rdata=0, s_valid=0, o_bus_err=0, o_err_sticky=0, o_err_cause=0, o_err_addr=0; counter=0.
- Reset mid-transaction: abort to IDLE, drop s_valid immediately, and issue no response.

## Timing
- Latency counts from the first cycle mem_valid is high (cycle 0):
  - IDLE decodes in cycle 0; s_valid is high from cycle 1.
  - A slave with ready at cycle k (k≥1) gives mem_ready at cycle k+1.
  - Registered 1-cycle BRAM: mem_ready at cycle 3.
  - Unmapped address: mem_ready at cycle 2.
  - Timeout: mem_ready at cycle TIMEOUT_CYCLES+1.
- mem_ready is never high for two consecutive cycles.
- At least one IDLE cycle separates transactions.
- s_addr, s_wdata and s_wstrb are combinational pass-throughs of the master fields.

## Configuration
- BUS_TIMEOUT_EN defined: watchdog counter is present and timeout errors occur as described.
- BUS_TIMEOUT_EN undefined:
  - Counter and TIMEOUT_CYCLES logic are compiled out.
  - WAIT holds indefinitely until the selected s_ready.
  - Cause 10 is never produced; unmapped-address errors are still generated.

## Test plan
- Read 0x0000_0010, slave 0 ready 1 cycle after s_valid with rdata 0x1234_5678 → mem_ready at cycle 3, mem_rdata=0x1234_5678, s_valid one-hot 0001 for exactly 2 cycles.
- Write 0x2000_0000 wstrb=0001 wdata=0x41, slave 2 ready combinationally at cycle 1 → mem_ready at cycle 2, s_valid=0100 for 1 cycle, no error.
- Read 0x5000_0000 → mem_ready at cycle 2, rdata=0xDEAD_BEEF, o_bus_err pulse, cause=01, o_err_addr=0x5000_0000, sticky=1; i_err_clr → sticky=0, cause=00.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, read 0x1000_0000 with slave 1 never ready → mem_ready at cycle 9, rdata=0xDEAD_BEEF, cause=10; repeat without macro → no mem_ready after 100 cycles.
- Overlap: slots 0 and 1 both match 0x0000_0000 → only s_valid[0] asserted. Reset pulled low in WAIT → next cycle s_valid=0, mem_ready=0, state IDLE.
